// File: rtl/load_store_unit_if.sv
// Request/response and data_memory signal bundle for load_store_unit.
// slave = the LSU's view; master = the execute stage plus memory side.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_is_store_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        misaligned_o;
  logic [31:0] mem_addr_o;
  logic        mem_read_enable_o;
  logic        mem_write_enable_o;
  logic [31:0] mem_write_data_o;
  logic [3:0]  mem_write_mask_o;
  logic [31:0] mem_read_data_i;
  logic        mem_busy_i;

  modport slave (
    input  req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  resp_ready_i, mem_read_data_i, mem_busy_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, misaligned_o,
    output mem_addr_o, mem_read_enable_o, mem_write_enable_o, mem_write_data_o, mem_write_mask_o
  );

  modport master (
    output req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output resp_ready_i, mem_read_data_i, mem_busy_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, misaligned_o,
    input  mem_addr_o, mem_read_enable_o, mem_write_enable_o, mem_write_data_o, mem_write_mask_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and data_memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int width_p = 32
) (
  input logic clk_i,
  input logic reset_i,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_STORE = 3'd2;
  localparam logic [2:0] ST_LOAD_DATA  = 3'd3;
  localparam logic [2:0] ST_RESP       = 3'd4;

  logic [2:0]         r_state;
  logic               r_is_store;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic [4:0]         r_rd;
  logic               r_mis;
  logic [width_p-1:0] r_mem_addr;
  logic [width_p-1:0] r_mem_wdata;
  logic [3:0]         r_mem_mask;
  logic               r_mem_re;
  logic               r_mem_we;
  logic [width_p-1:0] r_resp_data;

  logic               w_ready;
  logic               w_fire;
  logic               w_is_byte;
  logic               w_is_half;
  logic               w_mis;
  logic [width_p-1:0] w_st_data;
  logic [3:0]         w_st_mask;
  logic [7:0]         w_ld_byte;
  logic [15:0]        w_ld_half;
  logic [width_p-1:0] w_load_data;

  assign w_ready   = (r_state == ST_IDLE);
  assign w_fire    = bus.req_valid_i & w_ready;
  assign w_is_byte = (bus.req_funct3_i[1:0] == 2'b00);
  assign w_is_half = (bus.req_funct3_i[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = (w_is_half & bus.req_addr_i[0]) |
                 (!w_is_byte & !w_is_half & (bus.req_addr_i[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Lane placement ignores the low address bits a half/word does not use, which force-aligns them.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_st_data = bus.req_wdata_i;
    w_st_mask = 4'b1111;
    if (w_is_byte) begin
      w_st_data = {4{bus.req_wdata_i[7:0]}};
      w_st_mask = 4'b0001 << bus.req_addr_i[1:0];
    end else if (w_is_half) begin
      w_st_data = {2{bus.req_wdata_i[15:0]}};
      w_st_mask = 4'b0011 << {bus.req_addr_i[1], 1'b0};
    end
  end

  assign w_ld_byte = bus.mem_read_data_i[{r_off, 3'b000} +: 8];
  assign w_ld_half = bus.mem_read_data_i[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = bus.mem_read_data_i;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_load_data = {24'd0, w_ld_byte};
      3'b001:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_load_data = {16'd0, w_ld_half};
      default: w_load_data = bus.mem_read_data_i;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_rd        <= 5'd0;
      r_mis       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= 4'd0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_is_store  <= bus.req_is_store_i;
            r_funct3    <= bus.req_funct3_i;
            r_off       <= bus.req_addr_i[1:0];
            r_rd        <= bus.req_rd_i;
            r_mis       <= w_mis;
            r_mem_addr  <= {bus.req_addr_i[31:2], 2'b00};
            r_mem_wdata <= bus.req_is_store_i ? w_st_data : '0;
            r_mem_mask  <= bus.req_is_store_i ? w_st_mask : 4'd0;
            r_mem_re    <= !bus.req_is_store_i & !w_mis;
            r_mem_we    <= bus.req_is_store_i & !w_mis;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mis) begin
            r_resp_data <= '0;
            r_state     <= r_is_store ? ST_IDLE : ST_RESP;
          end else if (r_is_store) begin
            r_state <= bus.mem_busy_i ? ST_WAIT_STORE : ST_IDLE;
          end else begin
            r_state <= ST_LOAD_DATA;
          end
        end
        ST_WAIT_STORE: begin
          if (!bus.mem_busy_i) r_state <= ST_IDLE;
        end
        ST_LOAD_DATA: begin
          r_resp_data <= w_load_data;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o        = w_ready;
  assign bus.resp_valid_o       = (r_state == ST_RESP);
  assign bus.resp_data_o        = r_resp_data;
  assign bus.resp_rd_o          = r_rd;
  assign bus.mem_addr_o         = r_mem_addr;
  assign bus.mem_read_enable_o  = r_mem_re;
  assign bus.mem_write_enable_o = r_mem_we;
  assign bus.mem_write_data_o   = r_mem_wdata;
  assign bus.mem_write_mask_o   = r_mem_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  // A trapped store flags during its ISSUE cycle; a trapped load flags for its whole response.
  assign bus.misaligned_o = r_mis & (((r_state == ST_ISSUE) & r_is_store) | (r_state == ST_RESP));
`else
  assign bus.misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference model, per-cycle
// compare process, and directed transactions with hand-computed literal results.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.width_p(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- data_memory stand-in: busy in the write cycle and the next for partial writes
  bit [31:0] mem_arr [64];
  bit        busy_tail;
  bit [31:0] rdata_q;
  wire       partial_wr = bus.mem_write_enable_o && (bus.mem_write_mask_o != 4'hf);

  assign bus.mem_busy_i      = partial_wr || busy_tail;
  assign bus.mem_read_data_i = rdata_q;

  always @(posedge clk) begin
    if (rst) busy_tail <= 1'b0;
    else     busy_tail <= partial_wr;
    if (bus.mem_read_enable_o) rdata_q <= mem_arr[bus.mem_addr_o[7:2]];
    if (bus.mem_write_enable_o)
      for (int l = 0; l < 4; l++)
        if (bus.mem_write_mask_o[l])
          mem_arr[bus.mem_addr_o[7:2]][8*l +: 8] <= bus.mem_write_data_o[8*l +: 8];
  end

  // ---------------- reference model: byte-addressed memory, outcome computed per request
  typedef struct {
    bit        is_store;
    bit [31:0] addr;
    bit [4:0]  rd;
    bit        mis;
    bit        partial;
    bit [3:0]  mask;
    bit [31:0] lane_data;
    bit [31:0] ld_data;
  } txn_t;

  bit [7:0] ref_bytes [256];

  function automatic int size_of(input bit [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_mis(input bit [2:0] f3, input bit [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % size_of(f3)) != 0;
`else
    return (a == 32'hffff_ffff) && (f3 == 3'b111) && 1'b0;
`endif
  endfunction

  function automatic txn_t model_start(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                       input bit [31:0] wd, input bit [4:0] rd);
    txn_t t;
    int   sz  = size_of(f3);
    bit [31:0] eff = a - (a % sz);
    int   off = int'(eff % 4);
    bit [31:0] v = 32'd0;
    t.is_store  = st;
    t.addr      = a;
    t.rd        = rd;
    t.mis       = is_mis(f3, a);
    t.partial   = !t.mis && (sz < 4);
    t.mask      = 4'd0;
    t.lane_data = 32'd0;
    t.ld_data   = 32'd0;
    if (st) begin
      for (int l = 0; l < 4; l++) t.lane_data[8*l +: 8] = wd[8*(l % sz) +: 8];
      for (int i = 0; i < sz; i++) begin
        t.mask[off + i] = 1'b1;
        if (!t.mis) ref_bytes[8'(eff + 32'(i))] = wd[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[8'(eff + 32'(i))]) << (8*i));
      if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (~32'h0 << (8*sz));
      t.ld_data = t.mis ? 32'd0 : v;
    end
    return t;
  endfunction

  // ---------------- compare process: every cycle out of reset
  txn_t cur;
  bit   cur_active = 1'b0;
  int   cur_k      = 0;

  initial begin : compare
    int  resp_k;
    bit  done;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_active = 1'b0;
      end else begin
        if (!cur_active) begin
          check("idle_ready", 32'(bus.req_ready_o), 32'd1);
          check("idle_resp_valid", 32'(bus.resp_valid_o), 32'd0);
          check("idle_mem_en", 32'({bus.mem_read_enable_o, bus.mem_write_enable_o}), 32'd0);
          check("idle_misaligned", 32'(bus.misaligned_o), 32'd0);
        end else begin
          check("busy_ready", 32'(bus.req_ready_o), 32'd0);
          if (cur.is_store) begin
            check("st_re", 32'(bus.mem_read_enable_o), 32'd0);
            check("st_we", 32'(bus.mem_write_enable_o), 32'(!cur.mis && cur_k == 1));
            check("st_misaligned", 32'(bus.misaligned_o), 32'(cur.mis && cur_k == 1));
            if (!cur.mis) begin
              check("st_addr", bus.mem_addr_o, {cur.addr[31:2], 2'b00});
              check("st_mask", 32'(bus.mem_write_mask_o), 32'(cur.mask));
              check("st_wdata", bus.mem_write_data_o, cur.lane_data);
            end
          end else begin
            resp_k = cur.mis ? 2 : 3;
            check("ld_re", 32'(bus.mem_read_enable_o), 32'(!cur.mis && cur_k == 1));
            check("ld_we", 32'(bus.mem_write_enable_o), 32'd0);
            if (!cur.mis && cur_k == 1) check("ld_addr", bus.mem_addr_o, {cur.addr[31:2], 2'b00});
            check("ld_resp_valid", 32'(bus.resp_valid_o), 32'(cur_k >= resp_k));
            if (cur_k >= resp_k) begin
              check("ld_resp_data", bus.resp_data_o, cur.ld_data);
              check("ld_resp_rd", 32'(bus.resp_rd_o), 32'(cur.rd));
              check("ld_misaligned", 32'(bus.misaligned_o), 32'(cur.mis));
            end
          end
        end
        if (cur_active) begin
          if (cur.is_store) done = cur.partial ? (cur_k == 3) : (cur_k == 1);
          else              done = (cur_k >= (cur.mis ? 2 : 3)) && bus.resp_ready_i;
          if (done) cur_active = 1'b0;
          else      cur_k++;
        end else if (bus.req_valid_i) begin
          cur = model_start(bus.req_is_store_i, bus.req_funct3_i, bus.req_addr_i,
                            bus.req_wdata_i, bus.req_rd_i);
          cur_active = 1'b1;
          cur_k      = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit st, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, input bit [4:0] rd);
    int n = 0;
    while (!bus.req_ready_o && n < 50) begin
      step();
      n++;
    end
    check("wait_ready_bound", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_is_store_i = st;
    bus.req_funct3_i   = f3;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    bus.req_rd_i       = rd;
    step();
    bus.req_valid_i    = 1'b0;
  endtask

  task automatic do_store(input string name, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit [3:0] exp_mask, input int exp_lat);
    int lat = 1;
    send(1'b1, f3, a, wd, 5'd0);
    check({name, "_mask"}, 32'(bus.mem_write_mask_o), 32'(exp_mask));
    while (!bus.req_ready_o && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_ready_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_load(input string name, input bit [2:0] f3, input bit [31:0] a,
                         input bit [4:0] rd, input bit [31:0] exp_maddr,
                         input bit [31:0] exp_data, input bit hold);
    int lat = 1;
    if (hold) bus.resp_ready_i = 1'b0;
    send(1'b0, f3, a, 32'd0, rd);
    check({name, "_mem_addr"}, bus.mem_addr_o, exp_maddr);
    while (!bus.resp_valid_o && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_resp_latency"}, 32'(lat), 32'd3);
    check({name, "_data"}, bus.resp_data_o, exp_data);
    if (hold) begin
      repeat (4) begin
        step();
        check({name, "_held_valid"}, 32'(bus.resp_valid_o), 32'd1);
        check({name, "_held_data"}, bus.resp_data_o, exp_data);
        check({name, "_held_ready"}, 32'(bus.req_ready_o), 32'd0);
      end
      bus.resp_ready_i = 1'b1;
    end
    step();
    check({name, "_completed"}, 32'(bus.resp_valid_o), 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    check({name, "_resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    check({name, "_resp_data"}, bus.resp_data_o, 32'd0);
    check({name, "_resp_rd"}, 32'(bus.resp_rd_o), 32'd0);
    check({name, "_misaligned"}, 32'(bus.misaligned_o), 32'd0);
    check({name, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    check({name, "_mem_en"}, 32'({bus.mem_read_enable_o, bus.mem_write_enable_o}), 32'd0);
    check({name, "_mem_wdata"}, bus.mem_write_data_o, 32'd0);
    check({name, "_mem_mask"}, 32'(bus.mem_write_mask_o), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=no end of test required=end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.req_valid_i    = 1'b0;
    bus.req_is_store_i = 1'b0;
    bus.req_funct3_i   = 3'd0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    bus.req_rd_i       = 5'd0;
    bus.resp_ready_i   = 1'b1;

    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    do_store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 2);
    do_load ("lw_10", 3'b010, 32'h10, 5'd5, 32'h10, 32'hDEADBEEF, 1'b0);

    do_store("sw_10_base", 3'b010, 32'h10, 32'h11223344, 4'b1111, 2);
    do_store("sb_13", 3'b000, 32'h13, 32'h00000080, 4'b1000, 4);
    do_load ("lb_13",  3'b000, 32'h13, 5'd1, 32'h10, 32'hFFFFFF80, 1'b0);
    do_load ("lbu_13", 3'b100, 32'h13, 5'd2, 32'h10, 32'h00000080, 1'b0);
    do_load ("lw_10b", 3'b010, 32'h10, 5'd3, 32'h10, 32'h80223344, 1'b0);
    do_load ("ld_f3_011", 3'b011, 32'h10, 5'd4, 32'h10, 32'h80223344, 1'b0);

    do_store("sh_22", 3'b001, 32'h22, 32'h0000A5A5, 4'b1100, 4);
    do_load ("lhu_22", 3'b101, 32'h22, 5'd6, 32'h20, 32'h0000A5A5, 1'b0);
    do_load ("lh_22",  3'b001, 32'h22, 5'd7, 32'h20, 32'hFFFFA5A5, 1'b1);

    // Abort a partial store while it waits on the memory's read-modify-write.
    send(1'b1, 3'b000, 32'h31, 32'h0000005A, 5'd0);
    step();
    check("wait_store_busy_ready", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b1;
    step();
    check_reset_state("mid_reset");
    rst = 1'b0;
    step();
    check("after_reset_resp_valid", 32'(bus.resp_valid_o), 32'd0);

    do_store("sw_04", 3'b010, 32'h04, 32'hCAFEF00D, 4'b1111, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, 3'b010, 32'h06, 32'd0, 5'd9);
    check("lw_06_no_read", 32'(bus.mem_read_enable_o), 32'd0);
    step();
    check("lw_06_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    check("lw_06_misaligned", 32'(bus.misaligned_o), 32'd1);
    check("lw_06_data", bus.resp_data_o, 32'd0);
    step();
    check("lw_06_completed", 32'(bus.resp_valid_o), 32'd0);
`else
    do_load("lw_06", 3'b010, 32'h06, 5'd9, 32'h04, 32'hCAFEF00D, 1'b0);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
